// File: rtl/mm_feed_pkg.sv
// Shared types and sizing helpers for the matrix-multiply operand feeder.
// Optional rerun feature is selected with FEEDER_RERUN_EN.
package mm_feed_pkg;

  typedef enum logic [3:0] {
    IDLE, LOAD, LOADED, CLR, START, STREAM, STOP, WAIT, DONE
  } state_t;

  localparam int DATA_WIDTH_DEF  = 8;
  localparam int MAC_COUNT_DEF   = 8;
  localparam int VEC_LEN_DEF     = 8;
  localparam int SKEW_OFFSET_DEF = 1;

  // B vector followed by MAC_COUNT rows of A
  function automatic int load_count(input int vec_len, input int mac_count);
    return vec_len * (mac_count + 1);
  endfunction

  // last lane's last element lands at (VEC_LEN-1)+(MAC_COUNT-1)+SKEW_OFFSET
  function automatic int stream_len(input int vec_len, input int mac_count, input int skew);
    return vec_len + mac_count - 1 + skew;
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int LOAD_COUNT = load_count(VEC_LEN_DEF, MAC_COUNT_DEF);
  localparam int STREAM_LEN = stream_len(VEC_LEN_DEF, MAC_COUNT_DEF, SKEW_OFFSET_DEF);
  localparam int LCNT_W     = cnt_width(LOAD_COUNT);
  localparam int T_W        = cnt_width(STREAM_LEN);

endpackage

// File: rtl/mm_operand_feeder_if.sv
// Load stream, control and array-facing signals of the operand feeder.
// The rerun input exists only when FEEDER_RERUN_EN is defined.
interface mm_operand_feeder_if
  import mm_feed_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MAC_COUNT  = MAC_COUNT_DEF
);
  logic                                 in_valid;
  logic                                 in_ready;
  logic [DATA_WIDTH-1:0]                in_data;
  logic                                 go;
  logic                                 mm_done;
  logic [MAC_COUNT-1:0][DATA_WIDTH-1:0] A_out;
  logic [DATA_WIDTH-1:0]                B_out;
  logic                                 mm_clr;
  logic                                 mm_start;
  logic                                 mm_stop;
  logic                                 busy;
  logic                                 done;
`ifdef FEEDER_RERUN_EN
  logic                                 rerun;
`endif

  modport master (
`ifdef FEEDER_RERUN_EN
    output rerun,
`endif
    output in_valid, in_data, go, mm_done,
    input  in_ready, A_out, B_out, mm_clr, mm_start, mm_stop, busy, done
  );

  modport slave (
`ifdef FEEDER_RERUN_EN
    input  rerun,
`endif
    input  in_valid, in_data, go, mm_done,
    output in_ready, A_out, B_out, mm_clr, mm_start, mm_stop, busy, done
  );

endinterface

// File: rtl/mm_feed_skew_line.sv
// Per-lane delay line: q is d delayed by DEPTH cycles (DEPTH=0 is a wire).
module mm_feed_skew_line #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_thru
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign q = d;
  end else begin : g_dly
    localparam int SR_W = DEPTH * DATA_WIDTH;
    logic [SR_W-1:0] sr;
    always_ff @(posedge clk) begin
      if (rst) sr <= '0;
      else     sr <= (sr << DATA_WIDTH) | SR_W'(d);
    end
    assign q = sr[SR_W-1 -: DATA_WIDTH];
  end

endmodule

// File: rtl/mm_operand_feeder.sv
// Buffers B and A from a byte stream, then sequences clr/start/stream/stop for the MAC array.
// FEEDER_RERUN_EN adds a rerun input that replays the retained operands without reloading.
module mm_operand_feeder
  import mm_feed_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int MAC_COUNT   = MAC_COUNT_DEF,
  parameter int VEC_LEN     = VEC_LEN_DEF,
  parameter int SKEW_OFFSET = SKEW_OFFSET_DEF
) (
  input  logic                clk,
  input  logic                rst,
  mm_operand_feeder_if.slave  bus
);

  localparam int LOAD_N = load_count(VEC_LEN, MAC_COUNT);
  localparam int T_CYC  = stream_len(VEC_LEN, MAC_COUNT, SKEW_OFFSET);
  localparam int LC_W   = cnt_width(LOAD_N);
  localparam int TC_W   = cnt_width(T_CYC);

  state_t                state, state_n;
  logic [LC_W-1:0]       lcnt;
  logic [TC_W-1:0]       t;
  logic [DATA_WIDTH-1:0] mem [LOAD_N];
  logic                  accept, last_byte, stream_end, clr_buf;
  logic                  a_win;
  logic [LC_W-1:0]       k_idx;
  logic [MAC_COUNT-1:0][DATA_WIDTH-1:0] a_out;

  assign accept     = bus.in_valid & bus.in_ready;
  assign last_byte  = accept && (lcnt == LC_W'(LOAD_N - 1));
  assign stream_end = (t == TC_W'(T_CYC - 1));

`ifdef FEEDER_RERUN_EN
  logic retained;
  always_ff @(posedge clk) begin
    if (rst)                 retained <= 1'b0;
    else if (accept)         retained <= 1'b0;
    else if (state == DONE)  retained <= 1'b1;
  end
  // retained operands survive DONE; a fresh load wipes them on its first byte
  assign clr_buf = accept && (state == IDLE);
`else
  assign clr_buf = (state == DONE);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (bus.in_valid) state_n = LOAD;
`ifdef FEEDER_RERUN_EN
        else if (bus.rerun && retained) state_n = CLR;
`endif
      end
      LOAD:   if (last_byte) state_n = LOADED;
      LOADED: if (bus.go) state_n = CLR;
      CLR:    state_n = START;
      START:  state_n = STREAM;
      STREAM: if (stream_end) state_n = STOP;
      STOP:   state_n = WAIT;
      WAIT:   if (bus.mm_done) state_n = DONE;
      DONE: begin
        state_n = IDLE;
`ifdef FEEDER_RERUN_EN
        if (bus.rerun) state_n = CLR;
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)         lcnt <= '0;
    else if (accept) lcnt <= last_byte ? '0 : lcnt + 1'b1;
  end

  // t saturates at T-1 so it is stable through STOP/WAIT
  always_ff @(posedge clk) begin
    if (rst)                                 t <= '0;
    else if (state == START)                 t <= '0;
    else if (state == STREAM && !stream_end) t <= t + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < LOAD_N; j++) mem[j] <= '0;
    end else begin
      if (clr_buf)
        for (int j = 0; j < LOAD_N; j++) mem[j] <= '0;
      if (accept) mem[lcnt] <= bus.in_data;
    end
  end

  // rows enter unskewed at k = t-SKEW_OFFSET; each lane's delay line adds its row index
  assign a_win = (state == STREAM) && (t >= TC_W'(SKEW_OFFSET)) &&
                 (t <= TC_W'(SKEW_OFFSET + VEC_LEN - 1));
  assign k_idx = LC_W'(t - TC_W'(SKEW_OFFSET));

  for (genvar gi = 0; gi < MAC_COUNT; gi++) begin : g_lane
    logic [DATA_WIDTH-1:0] lane_d;
    assign lane_d = a_win ? mem[LC_W'(VEC_LEN * (gi + 1)) + k_idx] : '0;
    mm_feed_skew_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(gi)) u_skew (
      .clk (clk),
      .rst (rst),
      .d   (lane_d),
      .q   (a_out[gi])
    );
  end

  assign bus.A_out    = a_out;
  assign bus.B_out    = (state == STREAM && t <= TC_W'(VEC_LEN - 1)) ? mem[LC_W'(t)] : '0;
  assign bus.in_ready = (state == IDLE) || (state == LOAD);
  assign bus.mm_clr   = (state == CLR);
  assign bus.mm_start = (state == START);
  assign bus.mm_stop  = (state == STOP);
  assign bus.done     = (state == DONE);
  assign bus.busy     = !((state == IDLE) || (state == LOADED));

endmodule
